// File: rtl/aes_decryption_iterative.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// regenerated backwards from the last-round key, so no full key schedule is stored.
//
// state  | meaning
// NOKEY  | no valid key; waiting for kld
// KEYEXP | forward key schedule, one round key per edge, ending at k10
// READY  | k10 held; ciphertext accepted when in_valid
// ROUND  | one inverse round per edge, rnd 9 down to 0
// DONE   | plaintext on aes_output, held until out_ready
module aes_decryption_iterative #(
   parameter int nk = 4,
   parameter int nr = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             kld,
   input  logic [32*nk-1:0] cipher_key,
   output logic             key_ready,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     encrypted_text,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     aes_output,
   output logic             busy
);

   typedef enum logic [2:0] {NOKEY, KEYEXP, READY, ROUND, DONE} state_t;

   localparam logic [3:0] last_rnd = 4'(nr);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r, s;
      r = 8'h01;
      s = a;
      for (int i = 0; i < 7; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   state_t       state, state_nxt;
   logic [127:0] k0, k10, rk, blk;
   logic [3:0]   rnd;
   logic         load_key, accept, exp_last, rnd_last;

   logic [31:0]  w0, w1, w2, w3, sub_in, sub_word, rc_word;
   logic [127:0] fwd_key, inv_key, sub_bytes, ark, mix_out, round_out;

   assign {w0, w1, w2, w3} = rk;

   // The four forward S-boxes are shared: KEYEXP feeds w3, ROUND feeds the
   // reconstructed w3 of the previous key (w3 ^ w2).
   assign sub_in   = (state == ROUND) ? (w3 ^ w2) : w3;
   assign sub_word = {sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])};
   assign rc_word  = {rcon((state == ROUND) ? rnd + 4'd1 : rnd), 24'h000000};

   assign fwd_key[127:96] = w0 ^ sub_word ^ rc_word;
   assign fwd_key[95:64]  = w1 ^ fwd_key[127:96];
   assign fwd_key[63:32]  = w2 ^ fwd_key[95:64];
   assign fwd_key[31:0]   = w3 ^ fwd_key[63:32];
   assign inv_key         = {w0 ^ sub_word ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   for (genvar i = 0; i < 16; i++) begin : g_isb
      localparam int row = i % 4;
      localparam int src = row + 4 * (((i / 4) - row + 4) % 4);
      assign sub_bytes[127-8*i -: 8] = inv_sbox(blk[127-8*src -: 8]);
   end

   assign ark = sub_bytes ^ ((rnd == 4'd0) ? k0 : inv_key);

   for (genvar c = 0; c < 4; c++) begin : g_imc
      assign mix_out[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
   end

   assign round_out = (rnd == 4'd0) ? ark : mix_out;

   assign in_ready = key_ready & ~kld & ((state == READY) | ((state == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign busy     = (state == KEYEXP) | (state == ROUND);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= NOKEY;
      else       state <= state_nxt;
   end

   // Next-state decode and per-edge datapath strobes; kld takes priority over data.
   always_comb begin
      state_nxt = state;
      load_key  = 1'b0;
      exp_last  = 1'b0;
      rnd_last  = 1'b0;
      case (state)
         NOKEY: begin
            if (kld) begin load_key = 1'b1; state_nxt = KEYEXP; end
         end
         KEYEXP: begin
            if (rnd == last_rnd) begin exp_last = 1'b1; state_nxt = READY; end
         end
         READY: begin
            if (kld)         begin load_key = 1'b1; state_nxt = KEYEXP; end
            else if (accept) state_nxt = ROUND;
         end
         ROUND: begin
            if (rnd == 4'd0) begin rnd_last = 1'b1; state_nxt = DONE; end
         end
         DONE: begin
            if (kld)            begin load_key = 1'b1; state_nxt = KEYEXP; end
            else if (accept)    state_nxt = ROUND;
            else if (out_ready) state_nxt = READY;
         end
         default: state_nxt = NOKEY;
      endcase
   end

   // Key registers, round counter, cipher state and output handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         k0         <= '0;
         k10        <= '0;
         rk         <= '0;
         blk        <= '0;
         rnd        <= 4'd0;
         key_ready  <= 1'b0;
         out_valid  <= 1'b0;
         aes_output <= '0;
      end else if (load_key) begin
         k0        <= cipher_key;
         rk        <= cipher_key;
         rnd       <= 4'd1;
         key_ready <= 1'b0;
         out_valid <= 1'b0;
      end else if (state == KEYEXP) begin
         rk <= fwd_key;
         if (exp_last) begin
            k10       <= fwd_key;
            key_ready <= 1'b1;
         end else begin
            rnd <= rnd + 4'd1;
         end
      end else if (accept) begin
         blk       <= encrypted_text ^ k10;
         rk        <= k10;
         rnd       <= last_rnd - 4'd1;
         out_valid <= 1'b0;
      end else if (state == ROUND) begin
         rk  <= inv_key;
         blk <= round_out;
         if (rnd_last) begin
            aes_output <= round_out;
            out_valid  <= 1'b1;
         end else begin
            rnd <= rnd - 4'd1;
         end
      end else if ((state == DONE) && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_decryption_iterative.sv
// Bench for the iterative AES-128 decryption core: directed FIPS-197 vectors,
// handshake/abort scenarios, and random key/ciphertext pairs against a
// table-driven reference inverse cipher.
module tb_aes_decryption_iterative;

   logic         clk = 1'b0;
   logic         reset, kld, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] cipher_key, encrypted_text, aes_output;

   int n_cmp = 0;
   int n_bad = 0;

   int         alog [256];
   int         lg   [256];
   logic [7:0] sb_t [256];
   logic [7:0] isb_t[256];

   localparam logic [127:0] key1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] pt1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] pt2  = 128'h3243f6a8885a308d313198a2e0370734;

   always #5 clk = ~clk;

   aes_decryption_iterative dut (
      .clk            (clk),
      .reset          (reset),
      .kld            (kld),
      .cipher_key     (cipher_key),
      .key_ready      (key_ready),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .encrypted_text (encrypted_text),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .aes_output     (aes_output),
      .busy           (busy)
   );

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // GF(2^8) log/antilog tables from generator 3, then S-box = affine(inverse).
   task automatic build_tables();
      int         p;
      logic [7:0] inv, s;
      logic       bit_v;
      p = 1;
      for (int i = 0; i < 256; i++) lg[i] = 0;
      for (int i = 0; i < 255; i++) begin
         alog[i] = p;
         lg[p]   = i;
         p = p ^ ((p << 1) ^ (((p & 'h80) != 0) ? 'h11b : 0));
      end
      for (int a = 0; a < 256; a++) begin
         inv = (a == 0) ? 8'h00 : 8'(alog[(255 - lg[a]) % 255]);
         s   = 8'h63;
         for (int i = 0; i < 8; i++) begin
            bit_v = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
            s[i]  = s[i] ^ bit_v;
         end
         sb_t[a]  = s;
         isb_t[s] = 8'(a);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return 8'(alog[(lg[a] + lg[b]) % 255]);
   endfunction

   // Straight textbook inverse cipher over byte arrays with a fully expanded key.
   function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
      logic [7:0]   w  [176];
      logic [7:0]   s  [16];
      logic [7:0]   t  [16];
      logic [7:0]   tmp[4];
      logic [7:0]   coef[4];
      logic [7:0]   rc, x, acc;
      logic [127:0] res;
      coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      rc   = 8'h01;
      for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
         if (i % 16 == 0) begin
            x      = tmp[0];
            tmp[0] = sb_t[tmp[1]] ^ rc;
            tmp[1] = sb_t[tmp[2]];
            tmp[2] = sb_t[tmp[3]];
            tmp[3] = sb_t[x];
            rc     = gf_mul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
      for (int r_i = 9; r_i >= 0; r_i--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r + 4*((c + r) % 4)] = isb_t[s[r + 4*c]];
         for (int i = 0; i < 16; i++) t[i] = t[i] ^ w[16*r_i + i];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               acc = 8'h00;
               if (r_i > 0)
                  for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - r + 4) % 4], t[k + 4*c]);
               else
                  acc = t[r + 4*c];
               s[r + 4*c] = acc;
            end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs == exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts edges until key_ready; kld pulsed with a bogus key at edge index glitch.
   task automatic wait_key(input logic [127:0] key, input int glitch);
      int cnt;
      cnt = 0;
      while (key_ready !== 1'b1 && cnt < 40) begin
         kld        = (cnt == glitch);
         cipher_key = (cnt == glitch) ? ~key : key;
         step();
         cnt++;
      end
      kld        = 1'b0;
      cipher_key = key;
      check_int("key_latency", cnt, 10);
   endtask

   task automatic load_key(input logic [127:0] key, input int glitch);
      kld        = 1'b1;
      cipher_key = key;
      step();
      kld = 1'b0;
      check_bit("keyexp_busy", busy, 1'b1);
      check_bit("keyexp_key_ready", key_ready, 1'b0);
      wait_key(key, glitch);
   endtask

   task automatic accept_block(input logic [127:0] ct);
      int cnt;
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
      check_bit("in_ready_wait", in_ready, 1'b1);
      in_valid       = 1'b1;
      encrypted_text = ct;
      step();
      in_valid = 1'b0;
      check_bit("round_busy", busy, 1'b1);
   endtask

   task automatic wait_out(input string tag, input logic [127:0] exp, input int glitch);
      int cnt;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 40) begin
         kld        = (cnt == glitch);
         cipher_key = ~cipher_key;
         step();
         cnt++;
      end
      kld = 1'b0;
      check_int("out_latency", cnt, 10);
      check_vec(tag, aes_output, exp);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_bit("release_out_valid", out_valid, 1'b0);
      check_bit("release_busy", busy, 1'b0);
   endtask

   initial begin
      logic [127:0] k, ct, exp, held;
      build_tables();
      reset          = 1'b1;
      kld            = 1'b0;
      in_valid       = 1'b0;
      out_ready      = 1'b0;
      cipher_key     = '0;
      encrypted_text = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check_bit("rst_key_ready", key_ready, 1'b0);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_vec("rst_aes_output", aes_output, 128'h0);

      // FIPS-197 C.1 vector
      load_key(key1, -1);
      accept_block(ct1);
      wait_out("fips_c1", pt1, -1);
      release_out();

      // FIPS-197 appendix B vector, output then held back
      load_key(key2, -1);
      accept_block(ct2);
      wait_out("fips_b", pt2, -1);
      held = aes_output;
      for (int i = 0; i < 20; i++) begin
         step();
         check_bit("hold_out_valid", out_valid, 1'b1);
         check_vec("hold_aes_output", aes_output, held);
         check_bit("hold_in_ready", in_ready, 1'b0);
      end
      ct             = {$urandom, $urandom, $urandom, $urandom};
      out_ready      = 1'b1;
      in_valid       = 1'b1;
      encrypted_text = ct;
      #1;
      check_bit("handoff_in_ready", in_ready, 1'b1);
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_bit("handoff_out_valid", out_valid, 1'b0);
      check_bit("handoff_busy", busy, 1'b1);
      check_vec("handoff_output_kept", aes_output, pt2);
      wait_out("handoff_block", ref_decrypt(key2, ct), -1);
      release_out();

      // kld ignored during KEYEXP and ROUND
      load_key(key1, 3);
      accept_block(ct1);
      wait_out("kld_ignored", pt1, 4);
      release_out();

      // kld and in_valid together in READY: reload wins, nothing accepted
      kld            = 1'b1;
      cipher_key     = key1;
      in_valid       = 1'b1;
      encrypted_text = ct1;
      #1;
      check_bit("kld_blocks_in_ready", in_ready, 1'b0);
      step();
      kld      = 1'b0;
      in_valid = 1'b0;
      check_bit("reload_busy", busy, 1'b1);
      check_bit("reload_key_ready", key_ready, 1'b0);
      wait_key(key1, -1);
      check_bit("reload_no_output", out_valid, 1'b0);

      // reset in the middle of the rounds
      accept_block(ct1);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_bit("abort_out_valid", out_valid, 1'b0);
      check_bit("abort_key_ready", key_ready, 1'b0);
      check_bit("abort_busy", busy, 1'b0);
      check_vec("abort_aes_output", aes_output, 128'h0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         check_bit("nokey_in_ready", in_ready, 1'b0);
      end
      check_bit("nokey_no_output", out_valid, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // random key / ciphertext pairs
      for (int n = 0; n < 100; n++) begin
         k   = {$urandom, $urandom, $urandom, $urandom};
         ct  = {$urandom, $urandom, $urandom, $urandom};
         exp = ref_decrypt(k, ct);
         load_key(k, -1);
         accept_block(ct);
         wait_out("random_pair", exp, -1);
         release_out();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
